uart_tx_arb: RTL
================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of byte requesters (2..8).
REQ-002 Parameter TMO_CYC, default 1024, SHALL set the maximum cycles to wait for tx_tbre to fall after a strobe.
REQ-003 clk24m  input  1  SHALL be the single clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous assert, active-low, synchronous deassert handled upstream.
REQ-005 req_vld  input  NREQ  SHALL be per-requester "byte valid", level, held until accepted.
REQ-006 req_dat  input  8*NREQ  SHALL carry requester i's byte in bits [8*i+7:8*i].
REQ-007 req_rdy  output  NREQ  SHALL be a one-cycle accept pulse to the granted requester.
REQ-008 tx_dat  output  8  SHALL drive the transmitter's dat_in.
REQ-009 tx_wrn  output  1  SHALL be a one-cycle active-high write strobe to the transmitter.
REQ-010 tx_tbre  input  1  SHALL be the transmitter "buffer empty" status (high = can load).
REQ-011 tx_tsre  input  1  SHALL be the transmitter "shift register empty" status.
REQ-012 gnt_id  output  clog2(NREQ)  SHALL identify the requester whose byte is in flight.
REQ-013 busy  output  1  SHALL be high in every state except IDLE.
REQ-014 tmo_err  output  1  SHALL pulse for one cycle when a strobe times out.
REQ-015 tx_idle  output  1  SHALL equal (state==IDLE) and tx_tbre and tx_tsre.

Function
REQ-016 States SHALL be IDLE, LOAD, STRB, WBSY, WRDY.
REQ-017 IDLE -> LOAD when any req_vld bit is high and tx_tbre is high; otherwise remain.
REQ-018 Selection SHALL be round-robin: search starts at index (last_gnt+1) mod NREQ and wraps; first set req_vld bit wins.
REQ-019 LOAD SHALL capture the winner's byte into tx_dat, set gnt_id, pulse req_rdy[winner] for exactly this cycle, update last_gnt, go to STRB.
REQ-020 STRB SHALL assert tx_wrn for exactly one cycle, then go to WBSY; tx_dat SHALL be stable from LOAD until the next LOAD.
REQ-021 WBSY SHALL wait for tx_tbre low, then go to WRDY; a cycle counter SHALL count from 0, and at TMO_CYC-1 with tx_tbre still high, pulse tmo_err and return to IDLE.
REQ-022 WRDY SHALL wait for tx_tbre high, then return to IDLE; no timeout in WRDY.
REQ-023 Byte-to-byte minimum SHALL be 4 cycles plus transmitter latency; one byte in flight at most.
REQ-024 req_vld changes after LOAD SHALL not affect the byte in flight; deasserted requesters SHALL not be granted.
REQ-025 A single persistent requester SHALL be granted back-to-back; with all requesters valid, grants SHALL cycle 0,1,...,NREQ-1,0.
REQ-026 Timeout SHALL not restore the byte; the requester already received req_rdy.

Reset
REQ-027 On rst low: state=IDLE, tx_dat=8'h00, tx_wrn=0, req_rdy=0, gnt_id=0, busy=0, tmo_err=0, timeout counter=0, last_gnt=NREQ-1 (requester 0 wins first).
REQ-028 Reset mid-transfer SHALL abort immediately with no further tx_wrn; req_rdy already issued SHALL not be repeated.

Structure
REQ-029 Shared package uart_pkg SHALL hold the state encoding, default NREQ and TMO_CYC.
REQ-030 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req, last; outputs hit, idx).

Verification
REQ-031 Single: req_vld=4'b0100, req_dat[23:16]=8'hA5, tbre held high then low 3 cycles after strobe -> one req_rdy[2] pulse, tx_dat=8'hA5, one tx_wrn pulse, gnt_id=2.
REQ-032 Fairness: all four valid for 8 bytes -> grant order 0,1,2,3,0,1,2,3, each req_rdy exactly once per byte.
REQ-033 Back-pressure: tx_tbre low while req_vld=4'b0001 -> no LOAD, busy=0 until tbre rises, then grant within 1 cycle.
REQ-034 Timeout: tx_tbre never falls after strobe -> tmo_err pulse TMO_CYC cycles after WBSY entry, state IDLE, next requester granted.
REQ-035 Reset: rst low in WBSY -> all outputs at reset values same cycle, next grant goes to requester 0.
REQ-036 Withdraw: requester 1 drops req_vld before LOAD while 3 valid, last_gnt=0 -> requester 3 granted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit arbiter: FSM encoding and default sizing.
package uart_pkg;

  localparam int unsigned NREQ_DEF    = 4;
  localparam int unsigned TMO_CYC_DEF = 1024;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_STRB = 3'd2;
  localparam logic [2:0] ST_WBSY = 3'd3;
  localparam logic [2:0] ST_WRDY = 3'd4;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module rr_pick #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            hit,
  output logic [IW-1:0]   idx
);

  int unsigned cand;

  always_comb begin
    hit  = 1'b0;
    idx  = last;
    cand = 0;
    // k = NREQ lands back on 'last' itself, so it is considered last.
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (32'(last) + k) % NREQ;
      if (!hit && req[IW'(cand)]) begin
        hit = 1'b1;
        idx = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates NREQ byte requesters onto a single UART transmitter, one byte in flight.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter  int unsigned NREQ    = NREQ_DEF,
  parameter  int unsigned TMO_CYC = TMO_CYC_DEF,
  localparam int unsigned IW      = $clog2(NREQ)
) (
  input  logic              clk24m,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_vld,
  input  logic [8*NREQ-1:0] req_dat,
  output logic [NREQ-1:0]   req_rdy,
  output logic [7:0]        tx_dat,
  output logic              tx_wrn,
  input  logic              tx_tbre,
  input  logic              tx_tsre,
  output logic [IW-1:0]     gnt_id,
  output logic              busy,
  output logic              tmo_err,
  output logic              tx_idle
);

  localparam int unsigned CW = cnt_width(TMO_CYC);

  logic [2:0]      state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [IW-1:0]   last_gnt, last_nxt;
  logic [IW-1:0]   gnt_nxt;
  logic [NREQ-1:0] rdy_nxt;
  logic [7:0]      dat_nxt;
  logic            wrn_nxt, busy_nxt, tmo_nxt;
  logic            pick_hit;
  logic [IW-1:0]   pick_idx;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req  (req_vld),
    .last (last_gnt),
    .hit  (pick_hit),
    .idx  (pick_idx)
  );

  // Status for upstream: arbiter parked and transmitter fully drained.
  assign tx_idle = (state == ST_IDLE) & tx_tbre & tx_tsre;

  always_ff @(posedge clk24m or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      last_gnt <= IW'(NREQ - 1);
      gnt_id   <= '0;
      req_rdy  <= '0;
      tx_dat   <= 8'h00;
      tx_wrn   <= 1'b0;
      busy     <= 1'b0;
      tmo_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      last_gnt <= last_nxt;
      gnt_id   <= gnt_nxt;
      req_rdy  <= rdy_nxt;
      tx_dat   <= dat_nxt;
      tx_wrn   <= wrn_nxt;
      busy     <= busy_nxt;
      tmo_err  <= tmo_nxt;
    end
  end

  // Next-state and next-output logic; outputs are registered one cycle after decision.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    last_nxt  = last_gnt;
    gnt_nxt   = gnt_id;
    rdy_nxt   = '0;
    dat_nxt   = tx_dat;
    wrn_nxt   = 1'b0;
    tmo_nxt   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (pick_hit && tx_tbre) begin
          state_nxt = ST_LOAD;
          dat_nxt   = req_dat[{pick_idx, 3'b000} +: 8];
          gnt_nxt   = pick_idx;
          last_nxt  = pick_idx;
          rdy_nxt   = NREQ'(1) << pick_idx;
        end
      end
      ST_LOAD: begin
        state_nxt = ST_STRB;
        wrn_nxt   = 1'b1;
      end
      ST_STRB: state_nxt = ST_WBSY;
      ST_WBSY: begin
        if (!tx_tbre) begin
          state_nxt = ST_WRDY;
        end else if (cnt == CW'(TMO_CYC - 1)) begin
          // Byte is dropped: the requester was already acknowledged.
          state_nxt = ST_IDLE;
          tmo_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_WRDY: begin
        if (tx_tbre) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

endmodule
